// File: rtl/prog_loader.sv
// Boot-time instruction memory loader: assembles 9-bit words from a byte stream,
// writes them from address 0, verifies an XOR checksum, then releases the CPU.
module prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 9,
  parameter int RESET_HOLD = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               load_err
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_CHK, S_HOLD, S_RUN, S_ERR
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  count;
  logic [7:0]        csum;
  logic [7:0]        lo;
  logic [HOLD_W-1:0] hold_cnt;
  logic              xfer;
  logic              last_pair;
  logic              hold_last;

  assign in_ready  = (state != S_HOLD);
  assign xfer      = in_valid && in_ready;
  // Compare is CNT_W bits wide so LEN=0 (stored as 256) terminates after 256 pairs.
  assign last_pair = ((count + CNT_W'(1)) == len);
  assign hold_last = (hold_cnt == HOLD_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN, S_ERR: if (xfer) state_nxt = S_LO;
      S_LO:                 if (xfer) state_nxt = S_HI;
      S_HI:                 if (xfer) state_nxt = last_pair ? S_CHK : S_LO;
      S_CHK:                if (xfer) state_nxt = (in_data == csum) ? S_HOLD : S_ERR;
      S_HOLD:               if (hold_last) state_nxt = S_RUN;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      len       <= '0;
      count     <= '0;
      csum      <= '0;
      lo        <= '0;
      hold_cnt  <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      im_we     <= 1'b0;
      load_done <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (xfer) begin
            len       <= (in_data == 8'd0) ? CNT_W'(256) : CNT_W'(in_data);
            csum      <= in_data;
            count     <= '0;
            cpu_reset <= 1'b1;
            load_err  <= 1'b0;
          end
        end
        S_LO: begin
          if (xfer) begin
            lo   <= in_data;
            csum <= csum ^ in_data;
          end
        end
        S_HI: begin
          if (xfer) begin
            csum     <= csum ^ in_data;
            im_we    <= 1'b1;
            im_addr  <= count[ADDR_W-1:0];
            im_wdata <= INSTR_W'({in_data[0], lo});
            count    <= count + CNT_W'(1);
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (in_data == csum) hold_cnt <= HOLD_W'(RESET_HOLD);
            else                 load_err <= 1'b1;
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_last) begin
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Boot-time program writer for the 8-bit CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles 9-bit instructions from byte pairs. It writes them sequentially into instruction memory from address 0, checks an XOR checksum, and holds the CPU in reset until a load completes cleanly. It sits between the host/debug byte source and the CPU's `IM` write port and `reset` input.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit PC).
- INSTR_W, 9, instruction word width.
- RESET_HOLD, 2, cycles `cpu_reset` stays high after a good checksum, before release (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  loader can accept a byte; a transfer occurs when `in_valid && in_ready`.
- im_we  out  1  instruction memory write strobe, one cycle per instruction.
- im_addr  out  ADDR_W  write address.
- im_wdata  out  INSTR_W  write data.
- cpu_reset  out  1  reset to the CPU; high = CPU held.
- load_done  out  1  one-cycle pulse when `cpu_reset` is released.
- load_err  out  1  sticky checksum-mismatch flag.

Behaviour:
- Reset (synchronous, active-high):
  - state IDLE, count=0, csum=0.
  - `im_we`=0, `im_addr`=0, `im_wdata`=0.
  - `cpu_reset`=1, `load_done`=0, `load_err`=0, `in_ready`=1.
  - The CPU stays held after reset until a successful load.
- Stream format: LEN, then LEN pairs (LO, HI), then CHK.
  - LEN=0 means 256 instructions; the length register is 9 bits wide internally.
  - Instruction = {HI[0], LO}. HI[7:1] is ignored for data but included in the checksum.
  - CHK must equal the XOR of LEN and every LO/HI byte.
- States:
  - IDLE: `in_ready`=1. On a transfer: store LEN, csum=in_data, count=0, `cpu_reset`=1, `load_err`=0, go LO.
  - LO: `in_ready`=1. On a transfer: latch the low byte, csum^=in_data, go HI.
  - HI: `in_ready`=1. On a transfer: csum^=in_data; next cycle `im_we`=1, `im_addr`=count[7:0], `im_wdata`={in_data[0], lo}; count++. Go CHK if count+1==LEN (9-bit compare), else LO.
  - CHK: `in_ready`=1. On a transfer: if in_data==csum go HOLD with a hold counter of RESET_HOLD; else go ERR with `load_err`=1.
  - HOLD: `in_ready`=0, `cpu_reset`=1. Counter decrements each cycle. On the cycle it reaches 0: `cpu_reset`=0 and `load_done`=1 (registered, same cycle), go RUN.
  - RUN: `cpu_reset`=0, `in_ready`=1. Any transfer is a new LEN: same action as IDLE, and `cpu_reset` returns to 1 on the next cycle.
  - ERR: `cpu_reset`=1, `load_err`=1 held, `in_ready`=1. A transfer is a new LEN (as in IDLE), which clears `load_err`.
- Write timing:
  - `im_we` is registered, asserted exactly one cycle after each HI acceptance, then deasserts.
  - Addresses are strictly 0,1,2,... with no gaps.
  - The 256th write uses address 255; count[8] is used only for the compare.
- `in_valid` gaps: state holds, no writes, csum unchanged. Throughput is one byte per cycle.
- `in_data` is ignored whenever `in_valid`=0 or `in_ready`=0.
- Reset mid-load: returns to the reset state immediately. Memory already written is not rolled back. `cpu_reset` stays 1.
- `reset` has priority over any simultaneous transfer.
- `load_done` is never asserted in the same cycle as `im_we`.

Test Plan:
1. Good load (RESET_HOLD=2): send 02, 34, 00, 12, 01, 25 -> writes addr0=0x034 and addr1=0x112, one `im_we` cycle each. `cpu_reset` falls 2 cycles after the CHK transfer, `load_done` pulses once in that cycle, `load_err`=0.
2. Bad checksum: same stream with CHK=26 -> both writes occur, `load_err`=1, `cpu_reset` stays 1, no `load_done`. Then send the good stream -> `load_err` clears and the CPU is released.
3. Handshake gaps: the stream from test 1 with random `in_valid` idle cycles, and `in_valid` asserted during HOLD -> identical writes and release timing relative to the CHK transfer. No bytes are consumed during HOLD.
4. Mid-load reset: pulse `reset` after the first HI byte -> `cpu_reset`=1, `load_err`=0, state IDLE. A subsequent full load of test 1 succeeds from address 0.
5. Max length: LEN=00 followed by 256 pairs and the correct CHK -> 256 writes at addresses 0..255 in order, then release.
6. Reload from RUN: after test 1, send LEN=01 -> `cpu_reset`=1 on the next cycle. Send 7F, 01, CHK=7F -> addr0=0x17F, then release.
